viterbi_decoder: RTL and testbench
==================================

# viterbi_decoder

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-4, 8-state convolutional code produced by `convolutionencoder`. It sits at the receive end of the link and consumes one 2-bit code symbol per accepted cycle. Each step runs add-compare-select across all 8 states and keeps survivors by register exchange. It emits one decoded bit per symbol after a fixed decision depth.

## Interface
- `TB_DEPTH`, default 16: survivor length in symbols, which is also the decision depth. Legal range is 8..32.
- `MW`, default 6: path-metric width in bits. Minimum 5.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in_sym` is presented this cycle. There is no backpressure; the decoder accepts every valid cycle.
- `in_sym` in 2: code symbol. Bit [1] is the G1 output and bit [0] is the G0 output, with the same bit order as the encoder's `out`.
- `out_valid` out 1: `out_bit` is valid this cycle.
- `out_bit` out 1: decoded information bit.

## Operation
- **Code definition.** State `s[2:0]` holds `s[2]` = most recent input bit.
  - Next state = `{in, s[2:1]}`.
  - Output bit 1 = `in^s2^s1^s0` (G1 = 1111).
  - Output bit 0 = `in^s2^s0` (G0 = 1101).
- **Trellis connections.** For each state `s`:
  - Predecessors are `pA = {s[1:0],0}` and `pB = {s[1:0],1}`.
  - The input bit on both branches is `s[2]`.
  - The expected symbol per branch comes from the code definition, using predecessor bits as `s2..s0`.
- **Branch metric.** Hamming distance between `in_sym` and the expected symbol, giving 0..2.
- **ACS.** For each state, `cand = PM[p] + BM`, saturating at `2^MW-1`.
  - Select the smaller candidate.
  - On a tie, select `pA` (the lower index).
- **Normalisation.** Compute the minimum over all 8 new metrics. Store each new metric minus that minimum, so the stored minimum is always 0.
- **Survivors.** 8 registers, each `TB_DEPTH` bits wide.
  - New survivor of `s` = `{SURV[selected pred][TB_DEPTH-2:0], s[2]}`.
  - The MSB therefore holds the input from `TB_DEPTH-1` symbols earlier.
- **Best state.** The state with the minimum new metric. On a tie, take the lowest index.
- **Symbol counter.** Counts accepted symbols and saturates at `TB_DEPTH-1`. Output is enabled once the counter is saturated.
- **Tail handling.** No flush port. Upstream appends `TB_DEPTH-1` padding symbols to drain the final bits; encoding zeros is the intended padding.
- **Reset values:**
  - `PM[0]` = 0; `PM[1..7]` = `2^MW-1`, so decoding starts from state 0 to match encoder reset.
  - All survivors = 0; counter = 0.
  - `out_valid` = 0 and `out_bit` = 0.
- **Reset mid-stream.** Restores all of the above on the next edge. Symbols in flight are discarded, and no output is produced for them.

## Timing
- Metric update, ACS, survivor update and best-state selection all complete in the single cycle in which `in_valid`=1.
- `out_valid`/`out_bit` are registered at the edge that accepts symbol k, for k ≥ `TB_DEPTH-1` (k counts from 0 after reset).
  - `out_bit` is the MSB of the best state's new survivor, i.e. decoded bit number k-(`TB_DEPTH-1`).
  - Latency: 1 cycle after symbol k is accepted.
- `in_valid`=0: metrics, survivors and counter hold, and `out_valid` is 0 on the next cycle. `out_bit` holds its last value.
- Output count = accepted symbols − (`TB_DEPTH-1`). Exactly one output pulse follows each accepted symbol once the counter is saturated.
- Reset and `in_valid` asserted in the same cycle: reset wins and the symbol is dropped.

## Structure
- **Package `viterbi_pkg`** contains:
  - `NUM_STATES`=8, `K`=4, `G1`=4'b1111, `G0`=4'b1101.
  - Function `exp_sym(pred_state, in_bit)` returning 2 bits.
  - Function `hamming2(a,b)` returning 0..2.
- **Sub-module `viterbi_acs`.** One state's add-compare-select: inputs are two predecessor metrics and two branch metrics; outputs are the new metric and the decision bit. It is instantiated 8 times.
- **Top level** holds the metric and survivor registers, normalisation, best-state tree, counter and output register.

## Test plan
- **All zeros.** Reset, then 40 symbols of 2'b00 → first `out_valid` one cycle after symbol 15 (`TB_DEPTH`=16); 25 outputs, all 0.
- **Known pattern.** Feed the encoded form of 1,0,1,1 followed by 20 zeros: symbols 11,11,01,11,01,01,11,00,... → the first four outputs are 1,0,1,1, then all 0.
- **Error correction.** As the known-pattern case, but flip bit 1 of the third symbol (01→11) → output is identical to the error-free case.
- **Valid gaps.** Same stream with `in_valid` deasserted for 1–3 cycles at random → same decoded sequence; `out_valid` low in each cycle following a gap cycle.
- **Reset mid-stream.** Assert reset after 10 symbols, then replay the all-zeros case → matches the all-zeros results; no output pulse appears before the new 16th symbol.
- **Random soak.** 10k random bits through a behavioural copy of the encoder, with 1% random bit errors and zero padding → decoded output matches the source except for error bursts beyond the free distance. Metrics never wrap, and the stored minimum is 0 every cycle.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the rate-1/2, K=4 hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int NUM_STATES = 8;
    localparam int K          = 4;
    localparam logic [3:0] G1 = 4'b1111;
    localparam logic [3:0] G0 = 4'b1101;

    // Encoder register is {in, s2, s1, s0}; each generator taps it MSB-first.
    function automatic logic [1:0] exp_sym(input logic [2:0] pred_state, input logic in_bit);
        logic [3:0] reg_v;
        reg_v = {in_bit, pred_state};
        return {^(reg_v & G1), ^(reg_v & G0)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties resolve to predecessor A.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int MW = 6
) (
    input  logic [MW-1:0] pm_a,
    input  logic [MW-1:0] pm_b,
    input  logic [1:0]    bm_a,
    input  logic [1:0]    bm_b,
    output logic [MW-1:0] pm_new,
    output logic          dec
);

    logic [MW:0]   sum_a_s;
    logic [MW:0]   sum_b_s;
    logic [MW-1:0] cand_a_s;
    logic [MW-1:0] cand_b_s;

    assign sum_a_s = {1'b0, pm_a} + {{(MW-1){1'b0}}, bm_a};
    assign sum_b_s = {1'b0, pm_b} + {{(MW-1){1'b0}}, bm_b};

    // Saturate both candidates so unreachable states never wrap into small metrics.
    always_comb begin
        cand_a_s = sum_a_s[MW-1:0];
        cand_b_s = sum_b_s[MW-1:0];
        if (sum_a_s[MW]) begin
            cand_a_s = {MW{1'b1}};
        end else begin
            cand_a_s = sum_a_s[MW-1:0];
        end
        if (sum_b_s[MW]) begin
            cand_b_s = {MW{1'b1}};
        end else begin
            cand_b_s = sum_b_s[MW-1:0];
        end
    end

    // Strict less-than so an equal pair keeps predecessor A.
    always_comb begin
        dec    = 1'b0;
        pm_new = cand_a_s;
        if (cand_b_s < cand_a_s) begin
            dec    = 1'b1;
            pm_new = cand_b_s;
        end else begin
            dec    = 1'b0;
            pm_new = cand_a_s;
        end
    end

endmodule

// File: rtl/viterbi_decoder.sv
// 8-state register-exchange Viterbi decoder: one ACS step per accepted symbol, one bit out after TB_DEPTH-1 symbols.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int MW       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] in_sym,
    output logic       out_valid,
    output logic       out_bit
);

    localparam int CW = $clog2(TB_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(TB_DEPTH - 1);

    logic [MW-1:0]       pm_r        [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_r      [NUM_STATES];
    logic [MW-1:0]       pm_new_s    [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_next_s [NUM_STATES];
    logic [NUM_STATES-1:0] dec_s;
    logic [NUM_STATES-1:0] surv_msb_unused_s;
    logic [CW-1:0]       cnt_r;
    logic [MW-1:0]       min_s;
    logic [2:0]          best_s;

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_state
        localparam logic [2:0] ST = 3'(g);
        localparam logic [2:0] PA = {ST[1:0], 1'b0};
        localparam logic [2:0] PB = {ST[1:0], 1'b1};

        logic [1:0] bm_a_s;
        logic [1:0] bm_b_s;

        assign bm_a_s = hamming2(in_sym, exp_sym(PA, ST[2]));
        assign bm_b_s = hamming2(in_sym, exp_sym(PB, ST[2]));

        viterbi_acs #(.MW(MW)) u_acs (
            .pm_a   (pm_r[PA]),
            .pm_b   (pm_r[PB]),
            .bm_a   (bm_a_s),
            .bm_b   (bm_b_s),
            .pm_new (pm_new_s[g]),
            .dec    (dec_s[g])
        );

        // The oldest bit of each stored survivor is shifted out; only the new survivors feed the output.
        assign surv_next_s[g] = {(dec_s[g] ? surv_r[PB][TB_DEPTH-2:0] : surv_r[PA][TB_DEPTH-2:0]), ST[2]};
        assign surv_msb_unused_s[g] = surv_r[g][TB_DEPTH-1];
    end

    // Minimum new metric and its lowest-index state, shared by normalisation and the output decision.
    always_comb begin
        min_s  = pm_new_s[0];
        best_s = 3'd0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_new_s[i] < min_s) begin
                min_s  = pm_new_s[i];
                best_s = 3'(i);
            end else begin
                min_s  = min_s;
                best_s = best_s;
            end
        end
    end

    // Metric, survivor, counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_r[i]   <= (i == 0) ? {MW{1'b0}} : {MW{1'b1}};
                surv_r[i] <= {TB_DEPTH{1'b0}};
            end
            cnt_r     <= {CW{1'b0}};
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (in_valid) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_r[i]   <= pm_new_s[i] - min_s;
                surv_r[i] <= surv_next_s[i];
            end
            if (cnt_r == CNT_MAX) begin
                cnt_r     <= cnt_r;
                out_valid <= 1'b1;
                out_bit   <= surv_next_s[best_s][TB_DEPTH-1];
            end else begin
                cnt_r     <= cnt_r + CW'(1);
                out_valid <= 1'b0;
                out_bit   <= out_bit;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench: a behavioural encoder drives the decoder and source bits are queued for comparison.
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 16;
    localparam int MW       = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_sym;
    logic       out_valid;
    logic       out_bit;

    int   total = 0;
    int   bad   = 0;
    int   sent_run;
    int   out_run;
    logic last_bit;
    logic [2:0] enc_st;
    logic exp_q [$];

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .MW(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .out_valid (out_valid),
        .out_bit   (out_bit)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] enc_out(input logic [2:0] st, input logic b);
        return {b ^ st[2] ^ st[1] ^ st[0], b ^ st[2] ^ st[0]};
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_sym   = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_bit", out_bit, 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sym   = 2'b00;
        exp_q.delete();
        sent_run = 0;
        out_run  = 0;
        last_bit = 1'b0;
        enc_st   = 3'd0;
    endtask

    task automatic send_bit(input logic b, input logic [1:0] err);
        logic [1:0] sym;
        sym    = enc_out(enc_st, b) ^ err;
        enc_st = {b, enc_st[2:1]};
        exp_q.push_back(b);
        in_valid = 1'b1;
        in_sym   = sym;
        @(posedge clk);
        #1;
        sent_run++;
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("gap_out_valid", out_valid, 0);
            check_eq("gap_out_bit_hold", out_bit, last_bit);
        end
    endtask

    task automatic finish_run(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_out_count"}, out_run, sent_run - (TB_DEPTH - 1));
        check_eq({tag, "_tail_left"}, exp_q.size(), TB_DEPTH - 1);
    endtask

    task automatic send_pattern(input logic flip_third, input logic with_gaps);
        logic [3:0] head;
        head = 4'b1011;
        for (int i = 0; i < 24; i++) begin
            if (with_gaps && $urandom_range(0, 2) == 0) begin
                gap($urandom_range(1, 3));
            end
            send_bit((i < 4) ? head[3-i] : 1'b0, (flip_third && i == 2) ? 2'b10 : 2'b00);
        end
    endtask

    // Output monitor: latency relative to accepted symbols and decoded value against the source.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            check_eq("latency", sent_run - out_run, TB_DEPTH);
            check_eq("queue_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check_eq("decoded_bit", out_bit, exp_q.pop_front());
            end
            last_bit = out_bit;
            out_run++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_err;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sym   = 2'b00;
        sent_run = 0;
        out_run  = 0;
        last_bit = 1'b0;
        enc_st   = 3'd0;

        do_reset();
        for (int i = 0; i < 40; i++) send_bit(1'b0, 2'b00);
        finish_run("zeros");

        do_reset();
        send_pattern(1'b0, 1'b0);
        finish_run("pattern");

        do_reset();
        send_pattern(1'b1, 1'b0);
        finish_run("err_corr");

        do_reset();
        send_pattern(1'b0, 1'b1);
        finish_run("gaps");

        do_reset();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 2'b00);
        do_reset();
        for (int i = 0; i < 40; i++) send_bit(1'b0, 2'b00);
        finish_run("mid_reset");

        // Isolated single-bit errors are always within the correction capability of this code.
        do_reset();
        last_err = -100;
        for (int i = 0; i < 10000; i++) begin
            logic [1:0] err;
            err = 2'b00;
            if (i - last_err > 40 && $urandom_range(0, 99) == 0) begin
                err      = $urandom_range(0, 1) ? 2'b10 : 2'b01;
                last_err = i;
            end
            if ($urandom_range(0, 199) == 0) gap($urandom_range(1, 3));
            send_bit(1'($urandom_range(0, 1)), err);
        end
        for (int i = 0; i < TB_DEPTH - 1; i++) send_bit(1'b0, 2'b00);
        finish_run("soak");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
